// File: rtl/dvk_arb_pkg.sv
// Shared types and constants for the DVK system-bus arbiter.
package dvk_arb_pkg;

  // Arbiter FSM states: CPU owns the bus, drain the CPU, DMA tenure, dead cycle.
  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GRANT = 2'd2,
    ST_REL   = 2'd3
  } arb_state_e;

  // owner_o value meaning "CPU or nobody".
  localparam logic [3:0] OWNER_NONE = 4'd0;

  // Counter widths: hold counter covers MAX_HOLD up to 1023 with headroom
  // for strobe-deferred releases, gap counter covers CPU_GAP up to 15.
  localparam int HOLD_W = 11;
  localparam int GAP_W  = 4;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] index
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0] cand;

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (req[cand[IW-1:0]]) begin
        valid = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// System-bus arbiter between the K1801VM2 CPU (default owner) and NDMA
// DMA masters. The CPU grant is revoked only between CPU cycles; the bus
// then goes to one DMA master chosen round-robin, with a minimum CPU
// window between tenures and an optional maximum DMA hold time.
//
// Handshake: a DMA master raises dma_req_i[k] and holds it for its whole
// tenure; it may use the bus only while dma_gnt_o[k]=1 and ends the tenure
// by dropping dma_req_i[k]. The CPU may start cycles only while
// cpu_gnt_o=1; a cycle already started (cpu_stb_i=1) is always allowed to
// complete before any DMA grant is issued.
module dma_bus_arbiter
  import dvk_arb_pkg::*;
#(
  parameter int NDMA     = 4,
  parameter int CPU_GAP  = 4,
  parameter int MAX_HOLD = 1023
) (
  input  logic            clk_p,
  input  logic            rst_n,
  input  logic            cpu_stb_i,
  output logic            cpu_gnt_o,
  input  logic [NDMA-1:0] dma_req_i,
  output logic [NDMA-1:0] dma_gnt_o,
  input  logic [NDMA-1:0] dma_stb_i,
  output logic [3:0]      owner_o,
  output logic            dma_timeout_o,
  output arb_state_e      dbg_state_o
);

  localparam int                IDX_W    = (NDMA > 1) ? $clog2(NDMA) : 1;
  localparam logic [GAP_W:0]    GAP_LIM  = (GAP_W+1)'(CPU_GAP);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NDMA - 1);

  arb_state_e        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win;
  logic [GAP_W-1:0]  gap_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [NDMA-1:0]   pick_onehot;
  logic              gap_done;
  logic              gap_sat;
  logic              hold_hit;
  logic              win_req;
  logic              win_stb;

  arb_rr_pick #(
    .N  (NDMA),
    .IW (IDX_W)
  ) u_pick (
    .req   (dma_req_i),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // The current CPU cycle completes the required CPU window.
  assign gap_done = ({1'b0, gap_cnt} + {{GAP_W{1'b0}}, 1'b1}) >= GAP_LIM;
  assign gap_sat  = {1'b0, gap_cnt} >= GAP_LIM;
  // Hold limit reached (or passed while a strobe deferred the release).
  assign hold_hit = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM);
  assign win_req  = dma_req_i[win];
  assign win_stb  = dma_stb_i[win];

  assign dbg_state_o = state;

  // Decode the picker index into the one-hot grant vector.
  always_comb begin
    pick_onehot = '0;
    for (int i = 0; i < NDMA; i++) begin
      pick_onehot[i] = (pick_idx == IDX_W'(i));
    end
  end

  // Arbiter FSM with counters, pointer and registered outputs.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_CPU;
      ptr           <= '0;
      win           <= '0;
      gap_cnt       <= '0;
      hold_cnt      <= '0;
      cpu_gnt_o     <= 1'b1;
      dma_gnt_o     <= '0;
      owner_o       <= OWNER_NONE;
      dma_timeout_o <= 1'b0;
    end else begin
      dma_timeout_o <= 1'b0;
      case (state)
        ST_CPU: begin
          if (!gap_sat) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
          if (pick_valid && gap_done) begin
            state     <= ST_DRAIN;
            cpu_gnt_o <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!pick_valid) begin
            // Requests vanished: give the bus back, the CPU window stays met.
            state     <= ST_CPU;
            cpu_gnt_o <= 1'b1;
          end else if (!cpu_stb_i) begin
            state     <= ST_GRANT;
            win       <= pick_idx;
            dma_gnt_o <= pick_onehot;
            owner_o   <= 4'(pick_idx) + 4'd1;
          end
        end
        ST_GRANT: begin
          if (hold_cnt != {HOLD_W{1'b1}}) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          if (!win_req) begin
            state     <= ST_REL;
            dma_gnt_o <= '0;
            owner_o   <= OWNER_NONE;
          end else if (hold_hit && !win_stb) begin
            state         <= ST_REL;
            dma_gnt_o     <= '0;
            owner_o       <= OWNER_NONE;
            dma_timeout_o <= 1'b1;
          end
        end
        ST_REL: begin
          ptr       <= (win == LAST_IDX) ? '0 : win + IDX_W'(1);
          gap_cnt   <= '0;
          hold_cnt  <= '0;
          state     <= ST_CPU;
          cpu_gnt_o <= 1'b1;
        end
        default: begin
          state     <= ST_CPU;
          cpu_gnt_o <= 1'b1;
          dma_gnt_o <= '0;
          owner_o   <= OWNER_NONE;
        end
      endcase
    end
  end

endmodule
